cargador_instrucciones: RTL and testbench
=========================================

Name: cargador_instrucciones

Overview:
Program loader: the write side of the instruction memory that the single-cycle processor reads. Accepts a byte stream over a valid/ready handshake and packs it big-endian into 32-bit instructions. Writes those instructions to consecutive instruction-memory word addresses starting at 0. Holds the processor in reset while a load is in progress and releases it when the load completes.

Parameters:
ADDR_W, 6, instruction-memory word-address width; depth = 2**ADDR_W words
TIMEOUT_CYC, 1024, maximum idle cycles between bytes in RECV before the load is aborted

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle load request; honoured only in IDLE
word_count  input  ADDR_W+1  number of words to load; sampled on the cycle start is accepted
byte_in  input  8  stream data byte
byte_valid  input  1  byte_in holds a valid byte
byte_ready  output  1  loader accepts a byte this cycle
mem_we  output  1  instruction-memory write strobe
mem_addr  output  ADDR_W  instruction-memory word address
mem_wdata  output  32  assembled instruction word
cpu_reset  output  1  hold-reset to the processor
busy  output  1  load in progress
done  output  1  one-cycle pulse on successful completion
error  output  1  one-cycle pulse on a rejected start or a timeout

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- All outputs are registered.
- Reset values: state=IDLE, byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, cpu_reset=1.
- Reset asserted mid-load: return to IDLE. Discard the partial word; no write is issued. cpu_reset stays 1.
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - cpu_reset is held at its current value; it is 0 only after a successful load.
  - On start with 1 <= word_count <= 2**ADDR_W:
    - latch the count; set word index=0, byte counter=0;
    - set cpu_reset=1 and busy=1;
    - go to RECV.
  - On start with word_count=0 or word_count > 2**ADDR_W: pulse error, stay in IDLE, leave cpu_reset unchanged.
- RECV:
  - byte_ready=1.
  - A byte transfers when byte_valid & byte_ready.
  - Byte 0 goes to bits 31:24, byte 1 to 23:16, byte 2 to 15:8, byte 3 to 7:0.
  - After the 4th transfer, go to WRITE; byte_ready drops in the following cycle.
  - A gap counter resets on every transfer and increments on every RECV cycle without one.
  - Timeout: when the gap counter reaches TIMEOUT_CYC, pulse error, go to IDLE with busy=0 and cpu_reset=1. The program is incomplete; nothing already written is undone.
- WRITE:
  - Exactly one cycle with mem_we=1, mem_addr=word index, mem_wdata=assembled word.
  - If index = count-1: go to DONE. Otherwise increment the index, clear the byte counter and go to RECV.
- DONE: pulse done for one cycle; busy=0, cpu_reset=0; go to IDLE.
- Throughput with byte_valid held high: 5 cycles per word. mem_we for word k occurs 5k+5 cycles after the start cycle; done follows the last write by 1 cycle.
- start during RECV, WRITE or DONE: ignored.
- byte_valid while not in RECV: ignored; byte_ready=0.
- word_count = 2**ADDR_W: the index reaches 2**ADDR_W-1 and does not wrap; the address stays in range.

Decomposition:
- Shared package contains:
  - state encoding (IDLE, RECV, WRITE, DONE);
  - BYTES_PER_WORD=4 and the byte-lane constants;
  - the default ADDR_W=6, matching the processor's instruction-address width.
- One sub-module, ensamblador_palabra: a 4-byte big-endian shift/assemble register with a 2-bit byte counter. Inputs: load enable, clear, byte. Outputs: word, full flag.

Test Plan:
- Single word: start, word_count=1, bytes 8C,22,00,04 back-to-back -> one mem_we with mem_addr=0, mem_wdata=0x8C220004 five cycles after start; done the next cycle; cpu_reset 1->0.
- Three words with byte_valid toggling every other cycle -> writes only at addrs 0,1,2 with the correct words; no extra mem_we; byte_ready is 0 during the WRITE cycles.
- Rejected start: word_count=0, then word_count=65 (ADDR_W=6) -> error pulse each time, state stays IDLE, no mem_we, busy=0.
- Timeout: start with count=2, send 6 bytes, then stall 1024 cycles -> exactly one write at addr 0, error pulse, cpu_reset remains 1, byte_ready=0.
- Reset mid-load after 2 bytes of word 1 -> no write for the partial word; all outputs at reset values the next cycle; a fresh start then loads correctly from addr 0.
- Full depth: word_count=64 with continuous bytes -> the last write is at addr 63 at cycle 320 after start; no address wrap; done at cycle 321.

Source files
------------

// File: rtl/cargador_instrucciones_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// The default address width matches the processor's instruction-address width.
package cargador_instrucciones_pkg;

   localparam int unsigned ADDR_W_DEF     = 6;
   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned BYTE_W         = 8;

   // Byte-lane indices in arrival order: lane 0 is the most significant byte.
   localparam logic [1:0] LANE_FIRST = 2'd0;
   localparam logic [1:0] LANE_LAST  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RECV,
      ST_WRITE,
      ST_DONE
   } estado_t;

   // Bit position of the low bit of a byte lane in the big-endian word.
   function automatic int unsigned lane_lsb(input logic [1:0] lane);
      return (BYTES_PER_WORD - 1 - int'(lane)) * BYTE_W;
   endfunction

endpackage

// File: rtl/ensamblador_palabra.sv
// Big-endian word assembler: bytes fill the word from bits 31:24 downwards.
// full flags the load that completes the current word.
module ensamblador_palabra
   import cargador_instrucciones_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        clear,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        full
);

   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] word_q, word_d;

   always_comb begin
      cnt_d  = cnt_q;
      word_d = word_q;
      if (clear) begin
         cnt_d  = LANE_FIRST;
         word_d = '0;
      end else if (load) begin
         word_d[lane_lsb(cnt_q) +: BYTE_W] = byte_in;
         cnt_d = cnt_q + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= LANE_FIRST;
         word_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         word_q <= word_d;
      end
   end

   assign word = word_q;
   assign full = load & ~clear & (cnt_q == LANE_LAST);

endmodule

// File: rtl/cargador_instrucciones.sv
// Program loader: packs a byte stream into 32-bit words, writes them to
// instruction memory from address 0, and holds the CPU in reset meanwhile.
module cargador_instrucciones
   import cargador_instrucciones_pkg::*;
#(
   parameter int unsigned ADDR_W      = ADDR_W_DEF,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W:0]   word_count,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_reset,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int unsigned   GAP_W        = $clog2(TIMEOUT_CYC + 1);
   localparam logic [GAP_W-1:0] TIMEOUT_LAST = GAP_W'(TIMEOUT_CYC - 1);
   localparam logic [ADDR_W:0]  MAX_WORDS    = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]  ONE_WORD     = {{ADDR_W{1'b0}}, 1'b1};

   estado_t state_q, state_d;

   logic              byte_ready_q, byte_ready_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic              cpu_reset_q, cpu_reset_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [ADDR_W-1:0] last_q, last_d;
   logic [GAP_W-1:0]  gap_q, gap_d;

   logic              xfer;
   logic              count_ok;
   logic [ADDR_W:0]   count_m1;
   logic              asm_clear;
   logic              asm_full;
   logic [31:0]       asm_word;

   assign xfer     = (state_q == ST_RECV) & byte_valid & byte_ready_q;
   assign count_ok = (word_count != '0) && (word_count <= MAX_WORDS);
   assign count_m1 = word_count - ONE_WORD;

   ensamblador_palabra u_ensamblador (
      .clk     (clk),
      .reset   (reset),
      .load    (xfer),
      .clear   (asm_clear),
      .byte_in (byte_in),
      .word    (asm_word),
      .full    (asm_full)
   );

   always_comb begin
      state_d     = state_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      error_d     = 1'b0;
      cpu_reset_d = cpu_reset_q;
      idx_d       = idx_q;
      last_d      = last_q;
      gap_d       = gap_q;
      asm_clear   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (count_ok) begin
                  state_d     = ST_RECV;
                  last_d      = count_m1[ADDR_W-1:0];
                  idx_d       = '0;
                  gap_d       = '0;
                  asm_clear   = 1'b1;
                  busy_d      = 1'b1;
                  cpu_reset_d = 1'b1;
               end else begin
                  error_d = 1'b1;
               end
            end
         end
         ST_RECV: begin
            if (xfer) begin
               gap_d = '0;
               // Write strobe is registered so it lands in the WRITE cycle.
               if (asm_full) begin
                  state_d    = ST_WRITE;
                  mem_we_d   = 1'b1;
                  mem_addr_d = idx_q;
               end
            end else if (gap_q == TIMEOUT_LAST) begin
               state_d     = ST_IDLE;
               error_d     = 1'b1;
               busy_d      = 1'b0;
               cpu_reset_d = 1'b1;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         ST_WRITE: begin
            if (idx_q == last_q) begin
               state_d     = ST_DONE;
               done_d      = 1'b1;
               busy_d      = 1'b0;
               cpu_reset_d = 1'b0;
            end else begin
               state_d   = ST_RECV;
               idx_d     = idx_q + ADDR_W'(1);
               gap_d     = '0;
               asm_clear = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      byte_ready_d = (state_d == ST_RECV);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         byte_ready_q <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         cpu_reset_q  <= 1'b1;
         idx_q        <= '0;
         last_q       <= '0;
         gap_q        <= '0;
      end else begin
         state_q      <= state_d;
         byte_ready_q <= byte_ready_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         error_q      <= error_d;
         cpu_reset_q  <= cpu_reset_d;
         idx_q        <= idx_d;
         last_q       <= last_d;
         gap_q        <= gap_d;
      end
   end

   assign byte_ready = byte_ready_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = asm_word;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;
   assign cpu_reset  = cpu_reset_q;

endmodule

// File: tb/tb_cargador_instrucciones.sv
// Directed bench for the program loader: inputs change 1 time unit after the
// rising edge, DUT outputs are observed on the falling edge.
module tb_cargador_instrucciones;

   localparam int ADDR_W = 6;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [ADDR_W:0]   word_count;
   logic [7:0]        byte_in;
   logic              byte_valid;
   logic              byte_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              cpu_reset;
   logic              busy;
   logic              done;
   logic              error;

   cargador_instrucciones #(
      .ADDR_W      (ADDR_W),
      .TIMEOUT_CYC (1024)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .word_count (word_count),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .cpu_reset  (cpu_reset),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Write/pulse monitor, sampled on the falling edge.
   logic [ADDR_W-1:0] wr_addr[$];
   logic [31:0]       wr_data[$];
   int                wr_cyc[$];
   int done_cnt = 0, done_cyc = 0, err_cnt = 0, err_cyc = 0, ready_in_write = 0;

   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         wr_addr.push_back(mem_addr);
         wr_data.push_back(mem_wdata);
         wr_cyc.push_back(cyc);
         if (byte_ready !== 1'b0) ready_in_write++;
      end
      if (done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (error === 1'b1) begin
         err_cnt++;
         err_cyc = cyc;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;
   int t0       = 0;
   int last_xfer = 0;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      bit got;
      int n;
      byte_valid = 1'b0;
      repeat (gap) begin
         next_cycle();
         start = 1'b0;
      end
      byte_in    = b;
      byte_valid = 1'b1;
      got = 1'b0;
      n   = 0;
      while (!got && n < 50) begin
         @(negedge clk);
         got = (byte_ready === 1'b1);
         next_cycle();
         start = 1'b0;
         n++;
      end
      last_xfer = cyc;
      n_checks++;
      if (!got) begin
         n_fail++;
         $display("FAIL handshake byte %h: byte_ready never seen within %0d cycles", b, n);
      end
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      send_byte(w[31:24], gap);
      send_byte(w[23:16], gap);
      send_byte(w[15:8], gap);
      send_byte(w[7:0], gap);
   endtask

   task automatic do_start(input int n);
      start      = 1'b1;
      word_count = (ADDR_W+1)'(n);
      t0         = cyc;
   endtask

   task automatic wait_done(input int base, input int max_cyc);
      int n = 0;
      while (done_cnt == base && n < max_cyc) begin
         next_cycle();
         n++;
      end
      n_checks++;
      if (done_cnt != base + 1) begin
         n_fail++;
         $display("FAIL done_wait: done pulses got %0d expected %0d", done_cnt - base, 1);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; word_count = '0; byte_in = '0; byte_valid = 1'b0;
      repeat (3) next_cycle();
      reset = 1'b0;
      @(negedge clk);
      n_checks++; if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL rst_byte_ready: got %b expected 0", byte_ready); end
      n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we: got %b expected 0", mem_we); end
      n_checks++; if (mem_addr !== '0) begin n_fail++; $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); end
      n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_mem_wdata: got %h expected 0", mem_wdata); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b expected 0", done); end
      n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL rst_error: got %b expected 0", error); end
      n_checks++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL rst_cpu_reset: got %b expected 1", cpu_reset); end
      next_cycle();
   endtask

   task automatic test_single_word();
      int bw = wr_addr.size();
      int bd = done_cnt;
      do_start(1);
      send_word(32'h8C220004, 0);
      byte_valid = 1'b0;
      wait_done(bd, 20);
      n_checks++; if (wr_addr.size() != bw + 1) begin n_fail++; $display("FAIL single_nwrites: got %0d expected 1", wr_addr.size() - bw); end
      if (wr_addr.size() > bw) begin
         n_checks++; if (wr_addr[bw] !== 6'd0) begin n_fail++; $display("FAIL single_addr: got %h expected 0", wr_addr[bw]); end
         n_checks++; if (wr_data[bw] !== 32'h8C220004) begin n_fail++; $display("FAIL single_data: got %h expected 8c220004", wr_data[bw]); end
         n_checks++; if (wr_cyc[bw] != t0 + 5) begin n_fail++; $display("FAIL single_wr_latency: got %0d expected %0d", wr_cyc[bw] - t0, 5); end
      end
      n_checks++; if (done_cyc != t0 + 6) begin n_fail++; $display("FAIL single_done_latency: got %0d expected %0d", done_cyc - t0, 6); end
      n_checks++; if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL single_cpu_reset: got %b expected 0", cpu_reset); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b expected 0", busy); end
   endtask

   task automatic test_reject();
      int bw = wr_addr.size();
      int counts[2] = '{0, 65};
      for (int k = 0; k < 2; k++) begin
         int be = err_cnt;
         do_start(counts[k]);
         next_cycle();
         start = 1'b0;
         repeat (3) next_cycle();
         n_checks++; if (err_cnt != be + 1) begin n_fail++; $display("FAIL reject_err_count[%0d]: got %0d expected 1", counts[k], err_cnt - be); end
         n_checks++; if (err_cyc != t0 + 1) begin n_fail++; $display("FAIL reject_err_latency[%0d]: got %0d expected 1", counts[k], err_cyc - t0); end
         n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reject_busy[%0d]: got %b expected 0", counts[k], busy); end
         n_checks++; if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL reject_ready[%0d]: got %b expected 0", counts[k], byte_ready); end
         n_checks++; if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL reject_cpu_reset[%0d]: got %b expected 0", counts[k], cpu_reset); end
      end
      n_checks++; if (wr_addr.size() != bw) begin n_fail++; $display("FAIL reject_nwrites: got %0d expected 0", wr_addr.size() - bw); end
   endtask

   task automatic test_toggle();
      logic [31:0] words[3] = '{32'h20080005, 32'hAC080000, 32'h1000FFFF};
      int bw = wr_addr.size();
      int bd = done_cnt;
      int br = ready_in_write;
      do_start(3);
      for (int i = 0; i < 3; i++) send_word(words[i], 1);
      byte_valid = 1'b0;
      wait_done(bd, 40);
      repeat (3) next_cycle();
      n_checks++; if (wr_addr.size() != bw + 3) begin n_fail++; $display("FAIL toggle_nwrites: got %0d expected 3", wr_addr.size() - bw); end
      for (int i = 0; i < 3; i++) begin
         if (wr_addr.size() > bw + i) begin
            n_checks++; if (wr_addr[bw+i] !== 6'(i)) begin n_fail++; $display("FAIL toggle_addr[%0d]: got %h expected %h", i, wr_addr[bw+i], i); end
            n_checks++; if (wr_data[bw+i] !== words[i]) begin n_fail++; $display("FAIL toggle_data[%0d]: got %h expected %h", i, wr_data[bw+i], words[i]); end
         end
      end
      n_checks++; if (ready_in_write != br) begin n_fail++; $display("FAIL toggle_ready_in_write: got %0d expected 0", ready_in_write - br); end
   endtask

   task automatic test_timeout();
      int bw = wr_addr.size();
      int bd = done_cnt;
      int be = err_cnt;
      int lx;
      int n = 0;
      do_start(2);
      send_word(32'hDEADBEEF, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      byte_valid = 1'b0;
      lx = last_xfer;
      while (err_cnt == be && n < 1100) begin
         next_cycle();
         n++;
      end
      next_cycle();
      n_checks++; if (err_cnt != be + 1) begin n_fail++; $display("FAIL timeout_err_count: got %0d expected 1", err_cnt - be); end
      n_checks++; if (err_cyc != lx + 1024) begin n_fail++; $display("FAIL timeout_latency: got %0d expected 1024", err_cyc - lx); end
      n_checks++; if (wr_addr.size() != bw + 1) begin n_fail++; $display("FAIL timeout_nwrites: got %0d expected 1", wr_addr.size() - bw); end
      if (wr_addr.size() > bw) begin
         n_checks++; if (wr_addr[bw] !== 6'd0) begin n_fail++; $display("FAIL timeout_addr: got %h expected 0", wr_addr[bw]); end
         n_checks++; if (wr_data[bw] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL timeout_data: got %h expected deadbeef", wr_data[bw]); end
      end
      n_checks++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL timeout_cpu_reset: got %b expected 1", cpu_reset); end
      n_checks++; if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL timeout_ready: got %b expected 0", byte_ready); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %b expected 0", busy); end
      n_checks++; if (done_cnt != bd) begin n_fail++; $display("FAIL timeout_done: got %0d expected 0", done_cnt - bd); end
   endtask

   task automatic test_reset_mid();
      int bw = wr_addr.size();
      int bd;
      do_start(2);
      send_word(32'hCAFEF00D, 0);
      send_byte(8'h55, 0);
      send_byte(8'h66, 0);
      byte_valid = 1'b0;
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      n_checks++; if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL mid_byte_ready: got %b expected 0", byte_ready); end
      n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL mid_mem_we: got %b expected 0", mem_we); end
      n_checks++; if (mem_addr !== '0) begin n_fail++; $display("FAIL mid_mem_addr: got %h expected 0", mem_addr); end
      n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL mid_mem_wdata: got %h expected 0", mem_wdata); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b expected 0", busy); end
      n_checks++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL mid_cpu_reset: got %b expected 1", cpu_reset); end
      n_checks++; if (wr_addr.size() != bw + 1) begin n_fail++; $display("FAIL mid_nwrites: got %0d expected 1", wr_addr.size() - bw); end
      next_cycle();
      bw = wr_addr.size();
      bd = done_cnt;
      do_start(1);
      send_word(32'h01020304, 0);
      byte_valid = 1'b0;
      wait_done(bd, 20);
      n_checks++; if (wr_addr.size() != bw + 1) begin n_fail++; $display("FAIL mid_reload_nwrites: got %0d expected 1", wr_addr.size() - bw); end
      if (wr_addr.size() > bw) begin
         n_checks++; if (wr_addr[bw] !== 6'd0) begin n_fail++; $display("FAIL mid_reload_addr: got %h expected 0", wr_addr[bw]); end
         n_checks++; if (wr_data[bw] !== 32'h01020304) begin n_fail++; $display("FAIL mid_reload_data: got %h expected 01020304", wr_data[bw]); end
      end
   endtask

   task automatic test_full_depth();
      int bw = wr_addr.size();
      int bd = done_cnt;
      int bad = 0;
      logic [31:0] w;
      do_start(64);
      for (int i = 0; i < 64; i++) begin
         w = {8'(i), 8'hA5, ~8'(i), 8'h3C};
         send_word(w, 0);
      end
      byte_valid = 1'b0;
      wait_done(bd, 20);
      repeat (2) next_cycle();
      n_checks++; if (wr_addr.size() != bw + 64) begin n_fail++; $display("FAIL full_nwrites: got %0d expected 64", wr_addr.size() - bw); end
      if (wr_addr.size() >= bw + 64) begin
         for (int i = 0; i < 64; i++) begin
            w = {8'(i), 8'hA5, ~8'(i), 8'h3C};
            n_checks++;
            if (wr_addr[bw+i] !== 6'(i) || wr_data[bw+i] !== w) begin
               n_fail++;
               $display("FAIL full_word[%0d]: got addr %h data %h expected addr %h data %h",
                        i, wr_addr[bw+i], wr_data[bw+i], 6'(i), w);
            end
         end
         n_checks++; if (wr_cyc[bw+63] != t0 + 320) begin n_fail++; $display("FAIL full_last_wr_cycle: got %0d expected 320", wr_cyc[bw+63] - t0); end
      end
      n_checks++; if (done_cyc != t0 + 321) begin n_fail++; $display("FAIL full_done_cycle: got %0d expected 321", done_cyc - t0); end
      n_checks++; if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL full_cpu_reset: got %b expected 0", cpu_reset); end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_reject();
      test_toggle();
      test_timeout();
      test_reset_mid();
      test_full_depth();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
